// File: rtl/lab2_proc_drop_buffer.sv
// Response buffer that tracks outstanding requests and squashes stale responses on drop.
// Define LAB2_PROC_DROP_BUFFER_BYPASS_EN for a zero-latency path when the FIFO is empty.
module lab2_proc_drop_buffer #(
  parameter int p_msg_nbits    = 46,
  parameter int p_depth        = 2,
  parameter int p_max_inflight = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_fire,
  output logic                                  req_rdy,
  input  logic                                  drop,
  input  logic [p_msg_nbits-1:0]                istream_msg,
  input  logic                                  istream_val,
  output logic                                  istream_rdy,
  output logic [p_msg_nbits-1:0]                ostream_msg,
  output logic                                  ostream_val,
  input  logic                                  ostream_rdy,
  output logic [$clog2(p_max_inflight+1)-1:0]   inflight,
  output logic [31:0]                           drop_total
);

  localparam int c_cnt_nbits  = $clog2(p_max_inflight + 1);
  localparam int c_fill_nbits = $clog2(p_depth + 1);
  localparam int c_ptr_nbits  = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [c_cnt_nbits-1:0]  inflight_q, inflight_d;
  logic [c_cnt_nbits-1:0]  pend_q, pend_d;
  logic [c_fill_nbits-1:0] count_q, count_d;
  logic [c_ptr_nbits-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_ptr_nbits-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]             drop_total_q, drop_total_d;
  logic [p_msg_nbits-1:0]  mem_q [p_depth];

  logic fifo_empty, fifo_full, squashing;
  logic istream_fire, discard, keep, enq, deq, bypass_take;

  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
    return (p == c_ptr_nbits'(p_depth - 1)) ? '0 : p + c_ptr_nbits'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == c_fill_nbits'(p_depth));
  assign squashing  = drop || (pend_q != '0);

  // A full FIFO can still take a response when the head leaves in the same cycle.
  assign istream_rdy  = (inflight_q != '0) && (squashing || !fifo_full || ostream_rdy);
  assign istream_fire = istream_val && istream_rdy;
  assign discard      = istream_fire && squashing;
  assign keep         = istream_fire && !squashing;

`ifdef LAB2_PROC_DROP_BUFFER_BYPASS_EN
  logic bypass_val;
  assign bypass_val  = keep && fifo_empty;
  assign ostream_val = !drop && (!fifo_empty || bypass_val);
  assign ostream_msg = fifo_empty ? istream_msg : mem_q[rd_ptr_q];
  assign bypass_take = bypass_val && ostream_rdy;
`else
  assign ostream_val = !drop && !fifo_empty;
  assign ostream_msg = mem_q[rd_ptr_q];
  assign bypass_take = 1'b0;
`endif

  assign deq = ostream_val && ostream_rdy && !fifo_empty;
  assign enq = keep && !bypass_take;

  assign req_rdy    = (inflight_q != c_cnt_nbits'(p_max_inflight));
  assign inflight   = inflight_q;
  assign drop_total = drop_total_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    inflight_d   = inflight_q + c_cnt_nbits'(req_fire) - c_cnt_nbits'(istream_fire);
    pend_d       = pend_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    drop_total_d = drop_total_q + 32'(discard);

    if (drop) begin
      // Everything outstanding now is stale; a response arriving this cycle is already discarded.
      pend_d       = inflight_q - c_cnt_nbits'(istream_fire);
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      drop_total_d = drop_total_q + 32'(discard) + 32'(count_q);
    end else begin
      if (istream_fire && (pend_q != '0)) pend_d = pend_q - c_cnt_nbits'(1);
      if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + c_fill_nbits'(enq) - c_fill_nbits'(deq);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q   <= '0;
      pend_q       <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      drop_total_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      pend_q       <= pend_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      drop_total_q <= drop_total_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= istream_msg;
  end

endmodule

// File: tb/tb_lab2_proc_drop_buffer.sv
// Directed self-checking bench for lab2_proc_drop_buffer (default build, no bypass).
module tb_lab2_proc_drop_buffer;

  logic        clk;
  logic        reset;
  logic        req_fire;
  logic        req_rdy;
  logic        drop;
  logic [45:0] istream_msg;
  logic        istream_val;
  logic        istream_rdy;
  logic [45:0] ostream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [2:0]  inflight;
  logic [31:0] drop_total;

  int n_checks = 0;
  int n_fail   = 0;

  logic [45:0] got_q[$];
  logic [45:0] exp_q[$];

  localparam logic [45:0] MSG_A  = 46'h2_0000_0000_0A1;
  localparam logic [45:0] MSG_B  = 46'h1_1111_2222_0B2;
  localparam logic [45:0] MSG_C  = 46'h0_ABCD_EF01_0C3;
  localparam logic [45:0] MSG_D  = 46'h3_0000_0000_0D1;
  localparam logic [45:0] MSG_X1 = 46'h0_0000_0000_0F1;
  localparam logic [45:0] MSG_X2 = 46'h0_0000_0000_0F2;
  localparam logic [45:0] MSG_E  = 46'h1_2345_6789_0E1;
  localparam logic [45:0] MSG_R0 = 46'h2_5555_0000_000;
  localparam logic [45:0] MSG_R1 = 46'h2_5555_0000_001;
  localparam logic [45:0] MSG_R2 = 46'h2_5555_0000_002;
  localparam logic [45:0] MSG_R3 = 46'h2_5555_0000_003;
  localparam logic [45:0] MSG_Z  = 46'h0_7777_0000_0AA;
  localparam logic [45:0] MSG_Y  = 46'h0_7777_0000_0BB;
  localparam logic [45:0] MSG_W  = 46'h3_1357_9BDF_0CC;
  localparam logic [45:0] MSG_M0 = 46'h1_0000_0000_0E0;
  localparam logic [45:0] MSG_M1 = 46'h1_0000_0000_0E1;
  localparam logic [45:0] MSG_V  = 46'h2_4680_ACE0_0DD;

  lab2_proc_drop_buffer #(
    .p_msg_nbits   (46),
    .p_depth       (2),
    .p_max_inflight(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_fire   (req_fire),
    .req_rdy    (req_rdy),
    .drop       (drop),
    .istream_msg(istream_msg),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .ostream_msg(ostream_msg),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy),
    .inflight   (inflight),
    .drop_total (drop_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && ostream_val && ostream_rdy) got_q.push_back(ostream_msg);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic issue(input int n);
    req_fire = 1'b1;
    repeat (n) cyc();
    req_fire = 1'b0;
  endtask

  task automatic send(input logic [45:0] m, input string tag);
    istream_val = 1'b1;
    istream_msg = m;
    @(negedge clk);
    check(tag, 64'(istream_rdy), 64'd1);
    cyc();
    istream_val = 1'b0;
  endtask

  task automatic want(input logic [45:0] m);
    exp_q.push_back(m);
  endtask

  task automatic compare_out(input string tag);
    logic [45:0] g;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : '1;
      check({tag, "_msg"}, 64'(g), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    req_fire    = 1'b0;
    drop        = 1'b0;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b1;
    #1;
    check("rst_req_rdy",   64'(req_rdy),     64'd1);
    check("rst_irdy",      64'(istream_rdy), 64'd0);
    check("rst_oval",      64'(ostream_val), 64'd0);
    check("rst_inflight",  64'(inflight),    64'd0);
    check("rst_drop_tot",  64'(drop_total),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic ordered delivery with one-cycle latency
    issue(3);
    check("basic_inflight3", 64'(inflight), 64'd3);
    istream_val = 1'b1;
    istream_msg = MSG_A;
    @(negedge clk);
    check("basic_irdy_a", 64'(istream_rdy), 64'd1);
    check("basic_latency", 64'(ostream_val), 64'd0);
    cyc();
    istream_val = 1'b0;
    send(MSG_B, "basic_irdy_b");
    send(MSG_C, "basic_irdy_c");
    idle(2);
    check("basic_inflight0", 64'(inflight),   64'd0);
    check("basic_drop_tot",  64'(drop_total), 64'd0);
    want(MSG_A); want(MSG_B); want(MSG_C);
    compare_out("basic");

    // Squash with one buffered response and a request in the drop cycle
    ostream_rdy = 1'b0;
    issue(3);
    send(MSG_D, "sq_irdy_d");
    check("sq_inflight2", 64'(inflight), 64'd2);
    drop        = 1'b1;
    req_fire    = 1'b1;
    ostream_rdy = 1'b1;
    @(negedge clk);
    check("sq_oval_drop", 64'(ostream_val), 64'd0);
    cyc();
    drop     = 1'b0;
    req_fire = 1'b0;
    check("sq_drop_tot1",  64'(drop_total), 64'd1);
    check("sq_inflight3",  64'(inflight),   64'd3);
    check("sq_oval_flush", 64'(ostream_val), 64'd0);
    send(MSG_X1, "sq_irdy_x1");
    send(MSG_X2, "sq_irdy_x2");
    check("sq_drop_tot3", 64'(drop_total),  64'd3);
    check("sq_inflight1", 64'(inflight),    64'd1);
    check("sq_oval_none", 64'(ostream_val), 64'd0);
    send(MSG_E, "sq_irdy_e");
    idle(2);
    check("sq_inflight0", 64'(inflight), 64'd0);
    want(MSG_E);
    compare_out("sq");

    // Backpressure and inflight limit
    ostream_rdy = 1'b0;
    issue(4);
    check("lim_inflight4", 64'(inflight), 64'd4);
    check("lim_req_rdy0",  64'(req_rdy),  64'd0);
    send(MSG_R0, "bp_irdy_r0");
    check("lim_req_rdy1",  64'(req_rdy),  64'd1);
    check("lim_inflight3", 64'(inflight), 64'd3);
    send(MSG_R1, "bp_irdy_r1");
    istream_val = 1'b1;
    istream_msg = MSG_R2;
    @(negedge clk);
    check("bp_irdy_full", 64'(istream_rdy), 64'd0);
    cyc();
    check("bp_inflight2", 64'(inflight), 64'd2);
    ostream_rdy = 1'b1;
    @(negedge clk);
    check("bp_irdy_r2", 64'(istream_rdy), 64'd1);
    cyc();
    istream_msg = MSG_R3;
    @(negedge clk);
    check("bp_irdy_r3", 64'(istream_rdy), 64'd1);
    cyc();
    istream_val = 1'b0;
    idle(3);
    check("bp_inflight0", 64'(inflight), 64'd0);
    want(MSG_R0); want(MSG_R1); want(MSG_R2); want(MSG_R3);
    compare_out("bp");

    // Drop coinciding with a response and a new request
    issue(2);
    drop        = 1'b1;
    req_fire    = 1'b1;
    istream_val = 1'b1;
    istream_msg = MSG_Z;
    @(negedge clk);
    check("sim_irdy",     64'(istream_rdy), 64'd1);
    check("sim_oval",     64'(ostream_val), 64'd0);
    cyc();
    drop        = 1'b0;
    req_fire    = 1'b0;
    istream_val = 1'b0;
    check("sim_drop_tot4", 64'(drop_total), 64'd4);
    check("sim_inflight2", 64'(inflight),   64'd2);
    send(MSG_Y, "sim_irdy_y");
    check("sim_drop_tot5", 64'(drop_total), 64'd5);
    check("sim_inflight1", 64'(inflight),   64'd1);
    send(MSG_W, "sim_irdy_w");
    idle(2);
    check("sim_drop_final", 64'(drop_total), 64'd5);
    want(MSG_W);
    compare_out("sim");

    // Asynchronous reset with buffered and outstanding responses
    ostream_rdy = 1'b0;
    issue(4);
    send(MSG_M0, "rf_irdy_m0");
    send(MSG_M1, "rf_irdy_m1");
    check("rf_inflight2", 64'(inflight), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("rf_inflight",  64'(inflight),    64'd0);
    check("rf_req_rdy",   64'(req_rdy),     64'd1);
    check("rf_irdy",      64'(istream_rdy), 64'd0);
    check("rf_oval",      64'(ostream_val), 64'd0);
    check("rf_drop_tot",  64'(drop_total),  64'd0);
    cyc();
    reset       = 1'b0;
    ostream_rdy = 1'b1;
    idle(3);
    compare_out("rf_quiet");
    issue(1);
    send(MSG_V, "rf_irdy_v");
    idle(2);
    want(MSG_V);
    compare_out("rf_new");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_proc_drop_buffer.md
LAB2_PROC_DROP_BUFFER -- requirements
Module: lab2_proc_drop_buffer

Interface
REQ-001 SHALL have parameter p_msg_nbits, default 46, response message width in bits.
REQ-002 SHALL have parameter p_depth, default 2, response buffer entries (>=1).
REQ-003 SHALL have parameter p_max_inflight, default 4, maximum outstanding requests (>=1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_fire  input  1  a request was accepted downstream this cycle.
REQ-007 SHALL have port req_rdy  output  1  a new request may be issued.
REQ-008 SHALL have port drop  input  1  squash: discard all outstanding and buffered responses.
REQ-009 SHALL have ports istream_msg/val/rdy  input/input/output  p_msg_nbits/1/1  response in.
REQ-010 SHALL have ports ostream_msg/val/rdy  output/output/input  p_msg_nbits/1/1  response out.
REQ-011 SHALL have port inflight  output  clog2(p_max_inflight+1)  outstanding request count.
REQ-012 SHALL have port drop_total  output  32  running count of discarded responses.

Function
REQ-013 SHALL increment inflight on req_fire and decrement it on istream fire (val&&rdy); both in one cycle leave it unchanged.
REQ-014 SHALL drive req_rdy = (inflight != p_max_inflight); req_fire while req_rdy=0 is illegal input.
REQ-015 SHALL keep an internal drop_pending counter (same width as inflight) of future responses to discard.
REQ-016 SHALL, on drop, set drop_pending to inflight minus 1 if an istream fire occurs that cycle, else inflight; a req_fire in the drop cycle is not dropped.
REQ-017 SHALL drive istream_rdy = (inflight != 0) && (drop || drop_pending != 0 || buffer not full).
REQ-018 SHALL discard an istream fire when drop=1 or drop_pending!=0; when drop=0 and drop_pending!=0, drop_pending decrements by 1.
REQ-019 SHALL enqueue a non-discarded istream fire into a p_depth FIFO; ostream_msg/val present the FIFO head.
REQ-020 SHALL dequeue the head on ostream_val && ostream_rdy; simultaneous enqueue and dequeue when full is permitted only if ostream_rdy=1 (istream_rdy may use it).
REQ-021 SHALL flush the FIFO (count=0) on drop; ostream_val SHALL be 0 in any cycle with drop=1.
REQ-022 SHALL add to drop_total, per cycle, the number of discarded istream fires plus FIFO entries flushed; drop_total wraps modulo 2^32.
REQ-023 SHALL, without bypass, give one-cycle minimum latency from istream fire to ostream_val.
REQ-024 SHALL use wrapping read/write pointers modulo p_depth; full when count==p_depth, empty when count==0.

Reset
REQ-025 SHALL, while reset=1, asynchronously force inflight=0, drop_pending=0, FIFO count=0, pointers=0, drop_total=0.
REQ-026 SHALL, during reset, drive req_rdy=1, istream_rdy=0, ostream_val=0; reset mid-transaction abandons all state, no responses emitted.

Configuration
REQ-027 SHALL, with LAB2_PROC_DROP_BUFFER_BYPASS_EN defined, pass a non-discarded istream message combinationally to ostream when the FIFO is empty and ostream_rdy=1 (zero latency, not enqueued).
REQ-028 SHALL, without LAB2_PROC_DROP_BUFFER_BYPASS_EN, always register responses in the FIFO (REQ-023 latency).

Verification
REQ-029 Basic: p_depth=2; 3 req_fire, 3 responses A,B,C, ostream_rdy=1 -> ostream emits A,B,C in order, inflight returns to 0, drop_total=0.
REQ-030 Squash: 3 requests outstanding, 1 buffered response, pulse drop -> buffer flushed, next 2 responses discarded, drop_total=3, request issued in drop cycle delivered.
REQ-031 Backpressure: ostream_rdy=0, 4 requests, 4 responses -> istream_rdy=0 after 2 stored; releasing ostream_rdy delivers all 4 in order.
REQ-032 Limit: p_max_inflight=4; 4 req_fire without responses -> req_rdy=0, inflight=4; one response -> req_rdy=1.
REQ-033 Simultaneous: drop with concurrent istream fire and req_fire, inflight=2 -> arriving response discarded, drop_pending=1, inflight=2, drop_total=1.
REQ-034 Reset mid-flight: async reset with 2 buffered, 2 outstanding -> all outputs at reset values within same cycle, no ostream_val afterwards until new traffic.
